if_pc_fetch_unit: RTL

//  Fetch-stage program counter and IF/ID PC/valid pipeline register for the 5-stage RV64 core.

---
 rtl/if_pc_fetch_unit_if.sv | 39 +++
 rtl/if_pc_fetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/if_pc_fetch_unit_if.sv
// Fetch-stage control/status bundle between the hazard/EX logic (master) and the PC fetch unit (slave).
interface if_pc_fetch_unit_if;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] pc_out;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_halt;
    logic        misalign_err;

    modport master (
        output pc_write,
        output if_id_write,
        output if_id_flush,
        output branch_taken,
        output branch_target,
        input  pc_out,
        input  if_id_pc,
        input  if_id_valid,
        input  fetch_halt,
        input  misalign_err
    );

    modport slave (
        input  pc_write,
        input  if_id_write,
        input  if_id_flush,
        input  branch_taken,
        input  branch_target,
        output pc_out,
        output if_id_pc,
        output if_id_valid,
        output fetch_halt,
        output misalign_err
    );
endinterface

// File: rtl/if_pc_fetch_unit.sv
// Fetch-stage PC, IF/ID PC/valid register and BOOT/RUN/HALT control for the 5-stage RV64 core.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall/redirect performance counters.
module if_pc_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 264,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic                clk,
    input  logic                reset,
    if_pc_fetch_unit_if.slave   fetch_if
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_redirect_cnt
`endif
);

    localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;
    localparam logic [63:0] STEP    = 64'(PC_STEP);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [63:0] pc_q;
    logic [63:0] pc_next;
    logic [63:0] seq_pc;
    logic        misalign_q;
    logic        misalign_next;
    logic [63:0] if_id_pc_q;
    logic        if_id_valid_q;

    logic        in_run;
    logic        target_misaligned;
    logic        target_out_of_range;
    logic        redirect_ok;
    logic        seq_out_of_range;
    logic        if_id_capture;

    always_comb begin
        in_run              = (state == ST_RUN);
        seq_pc              = pc_q + STEP;
        target_misaligned   = (fetch_if.branch_target[1:0] != 2'b00);
        target_out_of_range = (fetch_if.branch_target > LAST_PC);
        seq_out_of_range    = (seq_pc > LAST_PC);
        redirect_ok         = fetch_if.branch_taken && !target_misaligned && !target_out_of_range;
        if_id_capture       = in_run && fetch_if.if_id_write
                              && !fetch_if.if_id_flush && !fetch_if.branch_taken;
    end

    // A redirect outranks a stall; any illegal next address parks the PC and halts fetch.
    always_comb begin
        pc_next       = pc_q;
        state_next    = state;
        misalign_next = misalign_q;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (fetch_if.branch_taken) begin
                    if (target_misaligned) begin
                        misalign_next = 1'b1;
                        state_next    = ST_HALT;
                    end else if (target_out_of_range) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next = fetch_if.branch_target;
                    end
                end else if (fetch_if.pc_write) begin
                    if (seq_out_of_range) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next = seq_pc;
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            misalign_q <= misalign_next;
        end
    end

    // if_id_pc is captured on the same edge imem registers its instruction, keeping them paired.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_pc_q    <= 64'h0;
            if_id_valid_q <= 1'b0;
        end else if (fetch_if.if_id_flush || fetch_if.branch_taken) begin
            if_id_valid_q <= 1'b0;
        end else if (!in_run) begin
            if_id_valid_q <= 1'b0;
        end else if (fetch_if.if_id_write) begin
            if_id_pc_q    <= pc_q;
            if_id_valid_q <= 1'b1;
        end
    end

    assign fetch_if.pc_out       = pc_q;
    assign fetch_if.if_id_pc     = if_id_pc_q;
    assign fetch_if.if_id_valid  = if_id_valid_q;
    assign fetch_if.fetch_halt   = (state == ST_HALT);
    assign fetch_if.misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;
    logic        stall_event;
    logic        redirect_event;

    assign stall_event    = in_run && !fetch_if.pc_write && !fetch_if.branch_taken;
    assign redirect_event = in_run && redirect_ok;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q    <= 32'h0;
            stall_cnt_q    <= 32'h0;
            redirect_cnt_q <= 32'h0;
        end else begin
            if (if_id_capture && (fetch_cnt_q != 32'hFFFF_FFFF))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_event && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_event && (redirect_cnt_q != 32'hFFFF_FFFF))
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt    = fetch_cnt_q;
    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`else
    logic unused_redirect_ok;
    logic unused_capture;
    assign unused_redirect_ok = redirect_ok;
    assign unused_capture     = if_id_capture;
`endif

endmodule
